// File: rtl/bmd_intr_moderator.sv
// ---------------------------------------------------------------------------
// bmd_intr_moderator
// Interrupt moderation ahead of the BMD interrupt controller. Completed DMA
// write packets are counted and collapsed into one single-cycle mwr_done_o
// pulse. A pulse fires on a packet-count threshold or on a timeout measured
// from the first pending packet, whichever comes first. Only one interrupt is
// outstanding at a time, and a programmable holdoff follows each acknowledge.
// ---------------------------------------------------------------------------
module bmd_intr_moderator #(
    parameter int CNT_W = 16,
    parameter int TMR_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_rst_i,
    input  logic             enable_i,
    input  logic             pkt_done_i,
    input  logic [CNT_W-1:0] pkt_thresh_i,
    input  logic [TMR_W-1:0] timeout_i,
    input  logic [CNT_W-1:0] holdoff_i,
    input  logic             intr_ack_i,
    output logic             mwr_done_o,
    output logic [CNT_W-1:0] batch_cnt_o,
    output logic [CNT_W-1:0] pending_cnt_o,
    output logic             overflow_o
);

    // One-hot encoding keeps each state decode to a single flop.
    typedef enum logic [4:0] {
        S_IDLE     = 5'b00001,
        S_ACCUM    = 5'b00010,
        S_FIRE     = 5'b00100,
        S_WAIT_ACK = 5'b01000,
        S_HOLDOFF  = 5'b10000
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    // Saturating packet-count increment: never wraps back to zero.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] val,
                                                     input logic inc);
        logic [CNT_W-1:0] res;
        if (inc && (val != CNT_MAX)) begin
            res = val + CNT_ONE;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Saturating timer increment: a disabled timeout must not wrap the timer.
    function automatic logic [TMR_W-1:0] sat_inc_tmr(input logic [TMR_W-1:0] val);
        logic [TMR_W-1:0] res;
        if (val != TMR_MAX) begin
            res = val + TMR_ONE;
        end else begin
            res = val;
        end
        return res;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_pending;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_hcnt;
    logic             r_mwr_done;
    logic [CNT_W-1:0] r_batch;
    logic             r_overflow;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_pending_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [CNT_W-1:0] w_batch_nxt;
    logic             w_overflow_nxt;

    logic             w_reset;
    logic             w_pkt_ev;
    logic [CNT_W-1:0] w_pend_inc;
    logic [CNT_W-1:0] w_thresh_eff;
    logic             w_thr_hit;
    logic             w_tmo_hit;

    assign w_reset      = rst | init_rst_i;
    assign w_pkt_ev     = pkt_done_i & enable_i;
    assign w_pend_inc   = sat_inc_cnt(r_pending, w_pkt_ev);
    // A threshold of zero behaves like one: every packet interrupts.
    assign w_thresh_eff = (pkt_thresh_i == CNT_ZERO) ? CNT_ONE : pkt_thresh_i;
    assign w_thr_hit    = (w_pend_inc >= w_thresh_eff);
    assign w_tmo_hit    = (timeout_i != TMR_ZERO) && (r_timer == (timeout_i - TMR_ONE));

    // Next-state and next-datapath decode for the moderation FSM.
    always_comb begin
        w_state_nxt    = r_state;
        w_pending_nxt  = r_pending;
        w_timer_nxt    = r_timer;
        w_hcnt_nxt     = r_hcnt;
        w_batch_nxt    = r_batch;
        w_overflow_nxt = r_overflow | (w_pkt_ev & (r_pending == CNT_MAX));

        case (r_state)
            S_IDLE: begin
                if (w_pkt_ev) begin
                    w_pending_nxt = CNT_ONE;
                    w_timer_nxt   = TMR_ZERO;
                    if (pkt_thresh_i <= CNT_ONE) begin
                        w_state_nxt = S_FIRE;
                    end else begin
                        w_state_nxt = S_ACCUM;
                    end
                end else begin
                    w_pending_nxt = CNT_ZERO;
                end
            end
            S_ACCUM: begin
                w_pending_nxt = w_pend_inc;
                if (w_thr_hit || w_tmo_hit) begin
                    w_state_nxt = S_FIRE;
                end else begin
                    w_timer_nxt = sat_inc_tmr(r_timer);
                end
            end
            S_FIRE: begin
                // A packet landing in the fire cycle opens the next batch.
                w_batch_nxt   = r_pending;
                w_pending_nxt = {{(CNT_W-1){1'b0}}, w_pkt_ev};
                w_state_nxt   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                w_pending_nxt = w_pend_inc;
                if (intr_ack_i) begin
                    if (holdoff_i != CNT_ZERO) begin
                        w_hcnt_nxt  = holdoff_i;
                        w_state_nxt = S_HOLDOFF;
                    end else if (w_pend_inc != CNT_ZERO) begin
                        w_timer_nxt = TMR_ZERO;
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_HOLDOFF: begin
                w_pending_nxt = w_pend_inc;
                if (r_hcnt <= CNT_ONE) begin
                    if (w_pend_inc != CNT_ZERO) begin
                        w_timer_nxt = TMR_ZERO;
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_pending_nxt = CNT_ZERO;
                w_timer_nxt   = TMR_ZERO;
                w_hcnt_nxt    = CNT_ZERO;
            end
        endcase
    end

    // State and datapath registers; the interrupt pulse is registered so it
    // is high exactly while the FSM sits in FIRE.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            r_state    <= S_IDLE;
            r_pending  <= CNT_ZERO;
            r_timer    <= TMR_ZERO;
            r_hcnt     <= CNT_ZERO;
            r_mwr_done <= 1'b0;
            r_batch    <= CNT_ZERO;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pending  <= w_pending_nxt;
            r_timer    <= w_timer_nxt;
            r_hcnt     <= w_hcnt_nxt;
            r_mwr_done <= (w_state_nxt == S_FIRE);
            r_batch    <= w_batch_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign mwr_done_o    = r_mwr_done;
    assign batch_cnt_o   = r_batch;
    assign pending_cnt_o = r_pending;
    assign overflow_o    = r_overflow;

endmodule
